// File: rtl/multi_sprite_locator.sv
// multi_sprite_locator
//
// Multi-sprite hit detector for the VGA pixel pipeline. For every pixel
// coordinate it reports which registered sprite covers the pixel (lowest
// index wins) and the sprite-local coordinates used to address the sprite ROM.
//
// Sprite parameters are written into a shadow bank through the cfg_* port.
// The whole shadow bank is copied into the active bank on frame_start, so a
// frame never sees a half-updated sprite. Hit detection reads only the
// active bank.
//
// Pipeline: two cycles from pix_valid/h_count/v_count to every output.
//   stage 1: per-slot hit vector and per-slot coordinate differences
//   stage 2: priority encode, mux, output registers
//
// Optional build macro: SPRITE_COLLISION_EN
//   defined   - sticky collision flag, set when two or more slots hit a valid
//               pixel, cleared by frame_start (a set in the same cycle wins)
//   undefined - no collision logic, collision tied to 0
//
// Ports:
//   clk, rst                   pixel clock, async active-high reset
//   cfg_we, cfg_idx            shadow write strobe and slot (out-of-range ignored)
//   cfg_x, cfg_y, cfg_w, cfg_h top-left corner and size of the sprite
//   cfg_en                     slot enable
//   frame_start                one-cycle pulse, commits shadow to active
//   pix_valid, h_count, v_count current pixel
//   out_valid                  pix_valid delayed by two cycles
//   visible, hit_idx           hit flag and winning slot
//   i_pos, j_pos               pixel position inside the winning sprite
//   collision                  sticky overlap flag
module multi_sprite_locator #(
    parameter int N_SPRITES = 4,
    parameter int COORD_W   = 10,
    parameter int SIZE_W    = 10,
    parameter int IDX_W     = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [IDX_W-1:0]   cfg_idx,
    input  logic [COORD_W-1:0] cfg_x,
    input  logic [COORD_W-1:0] cfg_y,
    input  logic [SIZE_W-1:0]  cfg_w,
    input  logic [SIZE_W-1:0]  cfg_h,
    input  logic               cfg_en,
    input  logic               frame_start,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] h_count,
    input  logic [COORD_W-1:0] v_count,
    output logic               out_valid,
    output logic               visible,
    output logic [IDX_W-1:0]   hit_idx,
    output logic [COORD_W-1:0] i_pos,
    output logic [COORD_W-1:0] j_pos,
    output logic               collision
);

    // Bound arithmetic is one bit wider than the widest operand so that
    // x + w never wraps: sprites hanging off the right/bottom are clipped.
    localparam int EXT_W = ((COORD_W > SIZE_W) ? COORD_W : SIZE_W) + 1;

    logic [COORD_W-1:0] sh_x  [N_SPRITES];
    logic [COORD_W-1:0] sh_y  [N_SPRITES];
    logic [SIZE_W-1:0]  sh_w  [N_SPRITES];
    logic [SIZE_W-1:0]  sh_h  [N_SPRITES];
    logic [N_SPRITES-1:0] sh_en;

    logic [COORD_W-1:0] act_x [N_SPRITES];
    logic [COORD_W-1:0] act_y [N_SPRITES];
    logic [SIZE_W-1:0]  act_w [N_SPRITES];
    logic [SIZE_W-1:0]  act_h [N_SPRITES];
    logic [N_SPRITES-1:0] act_en;

    // Shadow and active banks. Because both use non-blocking updates, a
    // commit in the same cycle as a write copies the pre-write shadow value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                sh_x[i]  <= '0;
                sh_y[i]  <= '0;
                sh_w[i]  <= '0;
                sh_h[i]  <= '0;
                act_x[i] <= '0;
                act_y[i] <= '0;
                act_w[i] <= '0;
                act_h[i] <= '0;
            end
            sh_en  <= '0;
            act_en <= '0;
        end else begin
            for (int i = 0; i < N_SPRITES; i++) begin
                if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                    sh_x[i]  <= cfg_x;
                    sh_y[i]  <= cfg_y;
                    sh_w[i]  <= cfg_w;
                    sh_h[i]  <= cfg_h;
                    sh_en[i] <= cfg_en;
                end
                if (frame_start) begin
                    act_x[i]  <= sh_x[i];
                    act_y[i]  <= sh_y[i];
                    act_w[i]  <= sh_w[i];
                    act_h[i]  <= sh_h[i];
                    act_en[i] <= sh_en[i];
                end
            end
        end
    end

    // ---------------- stage 1 ----------------
    logic [EXT_W-1:0]     h_ext;
    logic [EXT_W-1:0]     v_ext;
    logic [N_SPRITES-1:0] hit_c;
    logic [COORD_W-1:0]   di_c [N_SPRITES];
    logic [COORD_W-1:0]   dj_c [N_SPRITES];

    assign h_ext = EXT_W'(h_count);
    assign v_ext = EXT_W'(v_count);

    // Hits are gated by pix_valid here so stage 2 never sees a stale hit.
    // A zero width or height makes the half-open interval empty.
    always_comb begin
        hit_c = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            hit_c[i] = pix_valid && act_en[i]
                    && (h_ext >= EXT_W'(act_x[i]))
                    && (h_ext <  EXT_W'(act_x[i]) + EXT_W'(act_w[i]))
                    && (v_ext >= EXT_W'(act_y[i]))
                    && (v_ext <  EXT_W'(act_y[i]) + EXT_W'(act_h[i]));
            di_c[i] = h_count - act_x[i];
            dj_c[i] = v_count - act_y[i];
        end
    end

    logic                 s1_valid;
    logic [N_SPRITES-1:0] s1_hit;
    logic [COORD_W-1:0]   s1_di [N_SPRITES];
    logic [COORD_W-1:0]   s1_dj [N_SPRITES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_hit   <= '0;
            for (int i = 0; i < N_SPRITES; i++) begin
                s1_di[i] <= '0;
                s1_dj[i] <= '0;
            end
        end else begin
            s1_valid <= pix_valid;
            s1_hit   <= hit_c;
            for (int i = 0; i < N_SPRITES; i++) begin
                s1_di[i] <= di_c[i];
                s1_dj[i] <= dj_c[i];
            end
        end
    end

    // ---------------- stage 2 ----------------
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [COORD_W-1:0] win_i;
    logic [COORD_W-1:0] win_j;

    // Lowest index wins: only the first hitting slot is captured.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_i     = '0;
        win_j     = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (s1_hit[i] && !win_found) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(i);
                win_i     = s1_di[i];
                win_j     = s1_dj[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            visible   <= 1'b0;
            hit_idx   <= '0;
            i_pos     <= '0;
            j_pos     <= '0;
        end else begin
            out_valid <= s1_valid;
            visible   <= win_found;
            hit_idx   <= win_idx;
            i_pos     <= win_i;
            j_pos     <= win_j;
        end
    end

`ifdef SPRITE_COLLISION_EN
    logic multi_hit;

    assign multi_hit = ($countones(s1_hit) >= 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            collision <= 1'b0;
        end else if (s1_valid && multi_hit) begin
            collision <= 1'b1;
        end else if (frame_start) begin
            collision <= 1'b0;
        end
    end
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_multi_sprite_locator.sv
module tb_multi_sprite_locator;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [9:0] cfg_x, cfg_y, cfg_w, cfg_h;
    logic       cfg_en;
    logic       frame_start;
    logic       pix_valid;
    logic [9:0] h_count, v_count;
    logic       out_valid, visible, collision;
    logic [1:0] hit_idx;
    logic [9:0] i_pos, j_pos;

`ifdef SPRITE_COLLISION_EN
    localparam logic COLL = 1'b1;
`else
    localparam logic COLL = 1'b0;
`endif

    multi_sprite_locator #(.N_SPRITES(4), .COORD_W(10), .SIZE_W(10)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
        .cfg_en(cfg_en), .frame_start(frame_start),
        .pix_valid(pix_valid), .h_count(h_count), .v_count(v_count),
        .out_valid(out_valid), .visible(visible), .hit_idx(hit_idx),
        .i_pos(i_pos), .j_pos(j_pos), .collision(collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h; int v; int vis; int idx; int i; int j;
    } vec_t;

    typedef struct {
        int vis; int idx; int i; int j; int due;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_check++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard: every valid output pops one expectation, checked for latency too.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("latency_cycle", cyc, e.due);
                    chk("visible", visible, e.vis);
                    chk("hit_idx", hit_idx, e.idx);
                    chk("i_pos", i_pos, e.i);
                    chk("j_pos", j_pos, e.j);
                end
            end else if (q.size() > 0 && cyc > q[0].due) begin
                chk("missing_out_valid", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pix(input int h, input int v, input int vis, input int idx,
                       input int i, input int j);
        exp_t e;
        pix_valid = 1'b1;
        h_count   = 10'(h);
        v_count   = 10'(v);
        e.vis = vis; e.idx = idx; e.i = i; e.j = j; e.due = cyc + 2;
        q.push_back(e);
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
    endtask

    task automatic set_cfg(input int idx, input int x, input int y, input int w,
                           input int h, input int en);
        cfg_we  = 1'b1;
        cfg_idx = 2'(idx);
        cfg_x   = 10'(x);
        cfg_y   = 10'(y);
        cfg_w   = 10'(w);
        cfg_h   = 10'(h);
        cfg_en  = en[0];
    endtask

    task automatic cfg(input int idx, input int x, input int y, input int w,
                       input int h, input int en);
        set_cfg(idx, x, y, w, h, en);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        frame_start = 1'b1;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_visible"},   visible,   0);
        chk({tag, "_hit_idx"},   hit_idx,   0);
        chk({tag, "_i_pos"},     i_pos,     0);
        chk({tag, "_j_pos"},     j_pos,     0);
        chk({tag, "_collision"}, collision, 0);
    endtask

    vec_t tab[8];

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_x = '0; cfg_y = '0;
        cfg_w = '0; cfg_h = '0; cfg_en = 1'b0; frame_start = 1'b0;
        pix_valid = 1'b0; h_count = '0; v_count = '0;

        tab[0] = '{102, 53, 1, 0, 2, 3};
        tab[1] = '{105, 53, 0, 0, 0, 0};
        tab[2] = '{100, 50, 1, 0, 0, 0};
        tab[3] = '{104, 54, 1, 0, 4, 4};
        tab[4] = '{ 99, 50, 0, 0, 0, 0};
        tab[5] = '{104, 55, 0, 0, 0, 0};
        tab[6] = '{101, 49, 0, 0, 0, 0};
        tab[7] = '{103, 51, 1, 0, 3, 1};

        @(posedge clk); #1;
        idle(2);
        chk_all_zero("reset");
        rst = 1'b0;
        idle(2);

        // Single sprite, table-driven, including back-to-back pixels.
        cfg(0, 100, 50, 5, 5, 1);
        commit();
        for (int k = 0; k < 8; k++)
            pix(tab[k].h, tab[k].v, tab[k].vis, tab[k].idx, tab[k].i, tab[k].j);
        idle(3);

        // Priority between overlapping slots.
        cfg(1, 10, 10, 8, 8, 1);
        cfg(3, 10, 10, 8, 8, 1);
        commit();
        pix(12, 12, 1, 1, 2, 2);
        cfg(1, 10, 10, 8, 8, 0);
        commit();
        pix(12, 12, 1, 3, 2, 2);
        pix(17, 17, 1, 3, 7, 7);
        pix(18, 17, 0, 0, 0, 0);
        idle(3);

        // Shadow writes take effect only at commit.
        cfg(0, 200, 50, 5, 5, 1);
        pix(102, 53, 1, 0, 2, 3);
        pix(202, 53, 0, 0, 0, 0);
        commit();
        pix(202, 53, 1, 0, 2, 3);
        pix(102, 53, 0, 0, 0, 0);
        // Write and commit in the same cycle: change deferred one frame.
        set_cfg(0, 300, 50, 5, 5, 1);
        frame_start = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0; frame_start = 1'b0;
        pix(202, 53, 1, 0, 2, 3);
        pix(302, 53, 0, 0, 0, 0);
        commit();
        pix(302, 53, 1, 0, 2, 3);
        pix(202, 53, 0, 0, 0, 0);
        idle(3);

        // Right-edge clipping, no wrap-around.
        cfg(2, 1020, 0, 10, 4, 1);
        commit();
        for (int h = 1020; h <= 1023; h++) pix(h, 1, 1, 2, h - 1020, 1);
        for (int h = 0; h <= 5; h++)       pix(h, 1, 0, 0, 0, 0);
        cfg(2, 1020, 0, 0, 4, 1);
        commit();
        pix(1020, 1, 0, 0, 0, 0);
        pix(1023, 1, 0, 0, 0, 0);
        idle(3);

        // Collision flag.
        cfg(0, 500, 100, 4, 4, 1);
        cfg(2, 502, 100, 4, 4, 1);
        commit();
        idle(3);
        chk("collision_clear_start", collision, 0);
        pix(503, 101, 1, 0, 3, 1);
        idle(3);
        chk("collision_set", collision, COLL);
        pix(500, 100, 1, 0, 0, 0);
        idle(3);
        chk("collision_held", collision, COLL);
        commit();
        chk("collision_cleared", collision, 0);
        // Event reaches stage 2 in the same cycle as frame_start: set wins.
        pix(503, 101, 1, 0, 3, 1);
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
        idle(2);
        chk("collision_set_wins", collision, COLL);

        // Reset mid-stream flushes the pipeline and clears both banks.
        pix(503, 101, 1, 0, 3, 1);
        pix(503, 101, 1, 0, 3, 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);
        chk("post_reset_out_valid", out_valid, 0);
        pix(503, 101, 0, 0, 0, 0);
        idle(4);
        chk("post_reset_collision", collision, 0);

        chk("scoreboard_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
